bus_wait_responder: RTL and testbench

Module-side bus responder that terminates one synchronized output port of the CPU bus clock-domain crossing in the module clock domain. It decodes single-cycle bus strobes into a small word-addressed register bank and returns read data. With wait states configured, it drives the module busy handshake; the deasserting edge of busy signals completion to the crossing. It is the reference slave for every peripheral that needs multi-cycle access behind the crossing.

---
 rtl/bus_wait_responder.sv | 189 ++++++++++++++++++
 tb/tb_bus_wait_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_responder.sv
// Module-side responder for one synchronized port of the CPU bus crossing: a word-addressed
// register bank with optional wait states signalled on module_busy_o (falling edge = done).
module bus_wait_responder #(
  parameter int unsigned             AddressWidth = 32,
  parameter logic [AddressWidth-1:0] BaseAddress  = '0,
  parameter int unsigned             NumRegs      = 8,
  parameter int unsigned             WaitStates   = 3,
  parameter logic [31:0]             ResetValue   = '0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    we_i,
  input  logic [3:0]              we_ram_i,
  input  logic [AddressWidth-1:0] address_i,
  input  logic [31:0]             data_i,
  output logic [31:0]             data_o,
  output logic                    module_busy_o,
  output logic                    overrun_o
);

  localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  logic [AddressWidth-1:0] offset;
  logic [IdxW-1:0]         req_idx;
  logic                    in_window;
  logic                    wr_req;
  logic                    rd_req;
  logic                    req;

  logic [AddressWidth-1:0] address_q;
  logic                    in_window_q;

  // Commit port shared by both timing variants: one register write or readback per cycle.
  logic                    commit_en;
  logic                    commit_we;
  logic [3:0]              commit_be;
  logic [IdxW-1:0]         commit_idx;
  logic [31:0]             commit_wdata;
  logic                    overrun_set;
  logic                    busy;

  logic [31:0]             lane_mask;
  logic [31:0]             merged;

  logic [31:0]             regs_q [NumRegs];
  logic [31:0]             data_q;
  logic                    overrun_q;

  assign offset    = address_i - BaseAddress;
  assign in_window = (address_i >= BaseAddress) && (offset < AddressWidth'(4 * NumRegs));
  assign req_idx   = IdxW'(offset >> 2);

  // A held read strobe must not retrigger; only an address change or re-entry counts.
  assign wr_req = we_i && in_window;
  assign rd_req = !we_i && in_window && ((address_i != address_q) || !in_window_q);
  assign req    = wr_req || rd_req;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      address_q   <= '0;
      in_window_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      address_q   <= address_i;
      in_window_q <= in_window;
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < 4; k++) begin
      lane_mask[8*k +: 8] = {8{commit_be[k] || (commit_be == 4'b0000)}};
    end
  end

  assign merged = (regs_q[commit_idx] & ~lane_mask) | (commit_wdata & lane_mask);

  // NOTE: the bank is flops with an architectural reset value, so it is reset like any register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= ResetValue;
      end
      data_q <= '0;
    end else if (commit_en) begin
      if (commit_we) begin
        regs_q[commit_idx] <= merged;
        data_q             <= merged;
      end else begin
        data_q <= regs_q[commit_idx];
      end
    end
  end

  if (WaitStates == 0) begin : g_no_wait

    assign commit_en    = req;
    assign commit_we    = we_i;
    assign commit_be    = we_ram_i;
    assign commit_idx   = req_idx;
    assign commit_wdata = data_i;
    assign overrun_set  = 1'b0;
    assign busy         = 1'b0;

  end else begin : g_wait

    typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_d;
    logic            load;
    logic            lat_we_q;
    logic [3:0]      lat_be_q;
    logic [IdxW-1:0] lat_idx_q;
    logic [31:0]     lat_data_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        lat_we_q   <= 1'b0;
        lat_be_q   <= '0;
        lat_idx_q  <= '0;
        lat_data_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (load) begin
          lat_we_q   <= we_i;
          lat_be_q   <= we_ram_i;
          lat_idx_q  <= req_idx;
          lat_data_q <= data_i;
        end
      end
    end

    // The completing cycle still counts as busy: a request arriving then is dropped.
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load        = 1'b0;
      commit_en   = 1'b0;
      overrun_set = 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            load    = 1'b1;
            cnt_d   = 4'(WaitStates);
            state_d = BUSY;
          end
        end
        BUSY: begin
          overrun_set = req;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            commit_en = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign commit_we    = lat_we_q;
    assign commit_be    = lat_be_q;
    assign commit_idx   = lat_idx_q;
    assign commit_wdata = lat_data_q;
    assign busy         = (state_q == BUSY);

  end

  assign data_o        = data_q;
  assign module_busy_o = busy;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_bus_wait_responder.sv
// Bench for bus_wait_responder: a 3-wait-state instance and a zero-wait instance, checked
// against a scoreboard of expected read/write-through words.
module tb_bus_wait_responder;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        we_a;
  logic [3:0]  be_a;
  logic [31:0] addr_a;
  logic [31:0] wdata_a;
  logic [31:0] rdata_a;
  logic        busy_a;
  logic        ovr_a;

  logic        we_b;
  logic [3:0]  be_b;
  logic [31:0] addr_b;
  logic [31:0] wdata_b;
  logic [31:0] rdata_b;
  logic        busy_b;
  logic        ovr_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] zw_data  [5];
  logic [31:0] zw_model [4];

  always #5 clk = ~clk;

  bus_wait_responder #(
    .AddressWidth(32),
    .BaseAddress (32'h9000),
    .NumRegs     (8),
    .WaitStates  (3),
    .ResetValue  (32'hDEADBEEF)
  ) u_dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .we_i         (we_a),
    .we_ram_i     (be_a),
    .address_i    (addr_a),
    .data_i       (wdata_a),
    .data_o       (rdata_a),
    .module_busy_o(busy_a),
    .overrun_o    (ovr_a)
  );

  bus_wait_responder #(
    .AddressWidth(32),
    .BaseAddress (32'h0100),
    .NumRegs     (4),
    .WaitStates  (0),
    .ResetValue  (32'h0)
  ) u_zw (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .we_i         (we_b),
    .we_ram_i     (be_b),
    .address_i    (addr_b),
    .data_i       (wdata_b),
    .data_o       (rdata_b),
    .module_busy_o(busy_b),
    .overrun_o    (ovr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%h expected 'h%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_underflow: observed 'h%h with no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic drive_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] data);
    we_a    = we;
    be_a    = be;
    addr_a  = addr;
    wdata_a = data;
  endtask

  task automatic idle_a();
    drive_a(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic start_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] data);
    drive_a(we, be, addr, data);
    tick();
    idle_a();
  endtask

  // Counts the remaining busy cycles (bounded), then compares data_o with the scoreboard.
  task automatic finish_a(input string tag, input int exp_len);
    int n;
    n = 0;
    while (busy_a && n < 20) begin
      n++;
      tick();
    end
    check({tag, "_busy_len"}, 32'(n), 32'(exp_len));
    sb_pop_check(rdata_a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold_busy;

    zw_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
    zw_model = '{32'h0, 32'h0, 32'h0, 32'h0};

    reset_n = 1'b0;
    idle_a();
    we_b = 1'b0; be_b = 4'h0; addr_b = 32'h0; wdata_b = 32'h0;
    #1;
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_data_a", rdata_a, 32'h0);
    check("rst_ovr_a",  32'(ovr_a),  32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_data_b", rdata_b, 32'h0);
    tick();
    reset_n = 1'b1;

    // Write so data_o is non-zero, then reset mid-BUSY.
    sb_push("wr9010", 32'hCAFE_0001);
    start_a(1'b1, 4'h0, 32'h9010, 32'hCAFE_0001);
    finish_a("wr9010", 3);

    start_a(1'b0, 4'h0, 32'h9004, 32'h0);
    tick();
    check("midbusy_busy_pre", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_data", rdata_a, 32'h0);
    tick();
    reset_n = 1'b1;

    sb_push("rd9004_rst", 32'hDEADBEEF);
    start_a(1'b0, 4'h0, 32'h9004, 32'h0);
    finish_a("rd9004_rst", 3);
    sb_push("rd9010_rst", 32'hDEADBEEF);
    start_a(1'b0, 4'h0, 32'h9010, 32'h0);
    finish_a("rd9010_rst", 3);

    // Full-word write and readback, with hold after busy falls.
    sb_push("wr9008_full", 32'h1234_5678);
    start_a(1'b1, 4'h0, 32'h9008, 32'h1234_5678);
    finish_a("wr9008_full", 3);
    sb_push("rd9008_full", 32'h1234_5678);
    start_a(1'b0, 4'h0, 32'h9008, 32'h0);
    finish_a("rd9008_full", 3);
    tick();
    check("hold_data_1", rdata_a, 32'h1234_5678);
    tick();
    check("hold_data_2", rdata_a, 32'h1234_5678);

    // Byte-lane merge.
    sb_push("wr9008_lanes", 32'h12BB_56DD);
    start_a(1'b1, 4'b0101, 32'h9008, 32'hAABB_CCDD);
    finish_a("wr9008_lanes", 3);
    sb_push("rd9008_lanes", 32'h12BB_56DD);
    start_a(1'b0, 4'h0, 32'h9008, 32'h0);
    finish_a("rd9008_lanes", 3);
    check("ovr_clear", 32'(ovr_a), 32'd0);

    // Overrun: a write strobe one cycle into an access is dropped.
    sb_push("rd9008_ovr", 32'h12BB_56DD);
    drive_a(1'b0, 4'h0, 32'h9008, 32'h0);
    tick();
    drive_a(1'b1, 4'h0, 32'h900C, 32'h1111_1111);
    tick();
    idle_a();
    check("ovr_set", 32'(ovr_a), 32'd1);
    finish_a("rd9008_ovr", 2);
    check("ovr_sticky_1", 32'(ovr_a), 32'd1);
    sb_push("rd900c_ovr", 32'hDEADBEEF);
    start_a(1'b0, 4'h0, 32'h900C, 32'h0);
    finish_a("rd900c_ovr", 3);
    check("ovr_sticky_2", 32'(ovr_a), 32'd1);

    // Out-of-window strobe: no busy, no data change, no aliasing onto register 0.
    start_a(1'b1, 4'h0, 32'h9020, 32'h0BAD_F00D);
    check("oow_busy_1", 32'(busy_a), 32'd0);
    tick();
    check("oow_busy_2", 32'(busy_a), 32'd0);
    check("oow_data", rdata_a, 32'hDEADBEEF);
    sb_push("rd9000_oow", 32'hDEADBEEF);
    start_a(1'b0, 4'h0, 32'h9000, 32'h0);
    finish_a("rd9000_oow", 3);

    // Held read address: exactly one access over five cycles.
    sb_push("rd9004_hold", 32'hDEADBEEF);
    drive_a(1'b0, 4'h0, 32'h9004, 32'h0);
    hold_busy = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy_a) hold_busy++;
    end
    idle_a();
    check("hold_busy_cycles", 32'(hold_busy), 32'd3);
    sb_pop_check(rdata_a);
    tick();
    check("hold_busy_after", 32'(busy_a), 32'd0);

    // Zero wait states: alternate write/read every cycle over four registers.
    for (int i = 0; i < 5; i++) begin
      zw_model[i % 4] = zw_data[i];
      sb_push("zw_wr", zw_data[i]);
      we_b    = 1'b1;
      be_b    = 4'h0;
      addr_b  = 32'h100 + 32'(4 * (i % 4));
      wdata_b = zw_data[i];
      tick();
      check("zw_busy_wr", 32'(busy_b), 32'd0);
      sb_pop_check(rdata_b);

      sb_push("zw_rd", zw_model[(i + 3) % 4]);
      we_b    = 1'b0;
      addr_b  = 32'h100 + 32'(4 * ((i + 3) % 4));
      wdata_b = 32'h0;
      tick();
      check("zw_busy_rd", 32'(busy_b), 32'd0);
      sb_pop_check(rdata_b);
    end
    we_b   = 1'b0;
    addr_b = 32'h0;
    tick();
    check("zw_ovr", 32'(ovr_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
